// File: rtl/unit_input_buf_if.sv
// Arbiter-to-unit byte stream, flow control and core bank-read port for one unit_input_buf.
// master = arbiter/core side, slave = the input buffer.
interface unit_input_buf_if #(
   parameter int PKT_WORDS = 26
);
   localparam int AW = $clog2(PKT_WORDS);

   logic [7:0]    in_dat;
   logic          in_ctrl;
   logic          wr_en;
   logic          afull;
   logic          ready;
   logic [4:0]    init_dout;
   logic          init_valid;
   logic          bank_valid;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [31:0]   dout;
   logic          bank_done;
   logic          err;

   modport master (
      output in_dat, in_ctrl, wr_en, rd_en, rd_addr, bank_done,
      input  afull, ready, init_dout, init_valid, bank_valid, dout, err
   );

   modport slave (
      input  in_dat, in_ctrl, wr_en, rd_en, rd_addr, bank_done,
      output afull, ready, init_dout, init_valid, bank_valid, dout, err
   );
endinterface

// File: rtl/unit_input_buf.sv
// Unit receive stage: byte FIFO -> packet parser -> two 32-bit word banks read by the core.
// Read data 1 cycle after rd_en; core reads stall the parser; afull/ready throttle the arbiter.
module unit_input_buf #(
   parameter int WORD_MAX_LEN = 64,
   parameter int PKT_WORDS    = (WORD_MAX_LEN + 40) / 4,
   parameter int FIFO_DEPTH   = 16
) (
   input logic             clk_i,
   input logic             rst_n_i,
   unit_input_buf_if.slave bus
);
   localparam int FAW = $clog2(FIFO_DEPTH);
   localparam int CW  = FAW + 1;
   localparam int BCW = $clog2(4 * PKT_WORDS + 1);
   localparam int MAW = $clog2(2 * PKT_WORDS);
   localparam int AW  = $clog2(PKT_WORDS);
   localparam logic [BCW-1:0] BC_MIN_LAST = BCW'(43);
   localparam logic [BCW-1:0] BC_MAX_LAST = BCW'(4 * PKT_WORDS - 1);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_SKIP} state_e;

   logic [8:0]     fifo_q [FIFO_DEPTH];
   logic [31:0]    mem_q  [2 * PKT_WORDS];
   logic [CW-1:0]  wr_ptr_q, rd_ptr_q;
   logic           afull_q, ready_q, err_q, init_valid_q;
   logic [4:0]     init_dout_q;
   logic [31:0]    dout_q, pack_q;
   logic [1:0]     res_q, full_q;
   state_e         state_q;
   logic [BCW-1:0] bc_q;
   logic           pend_q, pend_last_q, pend_bank_q, wbank_q, rbank_q;
   logic [MAW-1:0] pend_addr_q;

   logic [CW-1:0]  fifo_cnt, cnt_d;
   logic           fifo_full, fifo_empty, push, ovf, pop, wr_commit;
   logic           hd_ctrl, end_ok, abort, done_ok, hdr_in, res_err;
   logic [7:0]     hd_byte;
   logic [31:0]    pack_d;
   logic [1:0]     res_d;
   logic [MAW-1:0] waddr, raddr;
   int             res_calc;

   always_comb begin
      fifo_cnt   = wr_ptr_q - rd_ptr_q;
      fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
      fifo_empty = (fifo_cnt == '0);
      push       = bus.wr_en & ~fifo_full;
      ovf        = bus.wr_en & fifo_full;
      // A held word blocked by a core read keeps the parser from popping.
      wr_commit  = pend_q & ~bus.rd_en;
      pop        = ~fifo_empty & (~pend_q | ~bus.rd_en);
      cnt_d      = fifo_cnt + CW'(push) - CW'(pop);
      {hd_ctrl, hd_byte} = fifo_q[rd_ptr_q[FAW-1:0]];

      pack_d = pack_q;
      pack_d[{bc_q[1:0], 3'b000} +: 8] = hd_byte;
      end_ok = (bc_q[1:0] == 2'd3) && (bc_q >= BC_MIN_LAST) && (bc_q <= BC_MAX_LAST);
      abort  = pop && (state_q == S_DATA) && (hd_ctrl ? ~end_ok : (bc_q == BC_MAX_LAST));
      waddr  = (wbank_q ? MAW'(PKT_WORDS) : '0) + MAW'(bc_q >> 2);
      raddr  = (rbank_q ? MAW'(PKT_WORDS) : '0) + MAW'(bus.rd_addr);

      done_ok  = bus.bank_done & full_q[rbank_q];
      hdr_in   = bus.wr_en & bus.in_ctrl & (bus.in_dat == 8'h00);
      res_calc = int'(res_q) + int'(hdr_in) - int'(done_ok) - int'(abort);
      res_err  = 1'b0;
      if (res_calc > 2) begin
         res_d   = 2'd2;
         res_err = 1'b1;
      end else if (res_calc < 0) begin
         res_d = 2'd0;
      end else begin
         res_d = 2'(res_calc);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push)
         fifo_q[wr_ptr_q[FAW-1:0]] <= {bus.in_ctrl, bus.in_dat};
      if (wr_commit)
         mem_q[pend_addr_q] <= pack_q;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         afull_q      <= 1'b0;
         ready_q      <= 1'b1;
         err_q        <= 1'b0;
         init_valid_q <= 1'b0;
         init_dout_q  <= '0;
         dout_q       <= '0;
         pack_q       <= '0;
         res_q        <= '0;
         full_q       <= '0;
         state_q      <= S_IDLE;
         bc_q         <= '0;
         pend_q       <= 1'b0;
         pend_last_q  <= 1'b0;
         pend_bank_q  <= 1'b0;
         pend_addr_q  <= '0;
         wbank_q      <= 1'b0;
         rbank_q      <= 1'b0;
      end else begin
         init_valid_q <= 1'b0;
         if (push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         afull_q <= (cnt_d >= CW'(FIFO_DEPTH - 4));
         res_q   <= res_d;
         ready_q <= (res_d != 2'd2);
         if (ovf | res_err | (bus.bank_done & ~full_q[rbank_q]))
            err_q <= 1'b1;

         if (bus.rd_en && (bus.rd_addr < AW'(PKT_WORDS)))
            dout_q <= mem_q[raddr];

         // A bank only becomes visible once its last word is in memory.
         if (wr_commit) begin
            pend_q <= 1'b0;
            if (pend_last_q)
               full_q[pend_bank_q] <= 1'b1;
         end
         if (done_ok) begin
            full_q[rbank_q] <= 1'b0;
            rbank_q         <= ~rbank_q;
         end

         if (pop) begin
            case (state_q)
               S_IDLE: begin
                  if (hd_ctrl && hd_byte == 8'h00) begin
                     if (full_q[wbank_q]) begin
                        err_q   <= 1'b1;
                        state_q <= S_SKIP;
                     end else begin
                        state_q <= S_DATA;
                        bc_q    <= '0;
                     end
                  end else if (hd_ctrl && hd_byte[2:0] == 3'b001) begin
                     init_dout_q  <= hd_byte[7:3];
                     init_valid_q <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
               S_DATA: begin
                  pack_q <= pack_d;
                  bc_q   <= bc_q + 1'b1;
                  if (hd_ctrl) begin
                     state_q <= S_IDLE;
                     if (end_ok) begin
                        pend_q      <= 1'b1;
                        pend_last_q <= 1'b1;
                        pend_addr_q <= waddr;
                        pend_bank_q <= wbank_q;
                        wbank_q     <= ~wbank_q;
                     end else begin
                        err_q <= 1'b1;
                     end
                  end else if (bc_q == BC_MAX_LAST) begin
                     err_q   <= 1'b1;
                     state_q <= S_SKIP;
                  end else if (bc_q[1:0] == 2'd3) begin
                     pend_q      <= 1'b1;
                     pend_last_q <= 1'b0;
                     pend_addr_q <= waddr;
                  end
               end
               S_SKIP: begin
                  if (hd_ctrl)
                     state_q <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.afull      = afull_q;
   assign bus.ready      = ready_q;
   assign bus.init_dout  = init_dout_q;
   assign bus.init_valid = init_valid_q;
   assign bus.bank_valid = full_q[rbank_q];
   assign bus.dout       = dout_q;
   assign bus.err        = err_q;
endmodule

// File: tb/tb_unit_input_buf.sv
// Bench for unit_input_buf: random packets checked against a queue model of expected bank words.
module tb_unit_input_buf;
   localparam int PKT_WORDS = 26;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   unit_input_buf_if #(.PKT_WORDS(PKT_WORDS)) bus ();

   unit_input_buf #(.WORD_MAX_LEN(64), .FIFO_DEPTH(16)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] exp_words[$];
   int          exp_lens[$];
   logic [2:0]  afull_hist = '0;
   int          afull_cnt = 0;

   // Arbiter view of afull, delayed like its 3-cycle loop.
   always @(negedge clk) begin
      afull_hist <= {afull_hist[1:0], bus.afull};
      if (bus.afull) afull_cnt <= afull_cnt + 1;
   end

   task automatic do_reset();
      bus.in_dat = '0; bus.in_ctrl = 1'b0; bus.wr_en = 1'b0;
      bus.rd_en = 1'b0; bus.rd_addr = '0; bus.bank_done = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      exp_words.delete();
      exp_lens.delete();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic c);
      int guard = 0;
      while (afull_hist[2] && guard < 400) begin
         @(posedge clk); #1; guard++;
      end
      if (guard >= 400) begin
         n_tests++; n_fail++;
         $display("FAIL flow_timeout: afull=%0b still set, required 0", afull_hist[2]);
      end
      bus.in_dat = b; bus.in_ctrl = c; bus.wr_en = 1'b1;
      @(posedge clk); #1;
      bus.wr_en = 1'b0; bus.in_ctrl = 1'b0;
   endtask

   // Sends header + len bytes; ctrl on the last byte. Good packets are added to the model.
   task automatic send_pkt(input int len, input bit seq, input bit good,
                           input bit chk_rdy, input logic exp_rdy);
      logic [7:0] b[$];
      for (int i = 0; i < len; i++) b.push_back(seq ? 8'(i) : 8'($urandom));
      send_byte(8'h00, 1'b1);
      if (chk_rdy) begin
         n_tests++;
         if (bus.ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL ready_after_hdr: got %0b required %0b", bus.ready, exp_rdy);
         end
      end
      for (int i = 0; i < len; i++) send_byte(b[i], i == len - 1);
      if (good) begin
         for (int w = 0; w < len / 4; w++)
            exp_words.push_back({b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]});
         exp_lens.push_back(len / 4);
      end
   endtask

   task automatic rd_word(input int a, output logic [31:0] d);
      bus.rd_en = 1'b1; bus.rd_addr = 5'(a);
      @(posedge clk); #1;
      bus.rd_en = 1'b0;
      d = bus.dout;
   endtask

   task automatic wait_bank(input string tag);
      int guard = 0;
      while (!bus.bank_valid && guard < 2000) begin
         @(posedge clk); #1; guard++;
      end
      n_tests++;
      if (bus.bank_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s bank_valid: got %0b required 1", tag, bus.bank_valid);
      end
   endtask

   task automatic read_bank(input string tag, input bit chk_rdy);
      int nw;
      logic [31:0] d, e;
      wait_bank(tag);
      nw = (exp_lens.size() > 0) ? exp_lens.pop_front() : 0;
      for (int i = 0; i < nw; i++) begin
         rd_word(i, d);
         e = exp_words.pop_front();
         n_tests++;
         if (d !== e) begin
            n_fail++;
            $display("FAIL %s word%0d: got %h required %h", tag, i, d, e);
         end
      end
      bus.bank_done = 1'b1;
      @(posedge clk); #1;
      bus.bank_done = 1'b0;
      if (chk_rdy) begin
         n_tests++;
         if (bus.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_after_done: got %0b required 1", tag, bus.ready);
         end
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      n_tests++;
      if ({bus.afull, bus.ready, bus.init_valid, bus.bank_valid, bus.err} !== 5'b01000) begin
         n_fail++;
         $display("FAIL %s flags{afull,ready,init_valid,bank_valid,err}: got %b required 01000", tag,
                  {bus.afull, bus.ready, bus.init_valid, bus.bank_valid, bus.err});
      end
      n_tests++;
      if (bus.dout !== 32'h0 || bus.init_dout !== 5'h0) begin
         n_fail++;
         $display("FAIL %s data: dout=%h init_dout=%h required 0/0", tag, bus.dout, bus.init_dout);
      end
   endtask

   task automatic check_err(input string tag, input logic exp_err);
      repeat (10) @(posedge clk);
      #1;
      n_tests++;
      if ({bus.err, bus.ready, bus.bank_valid} !== {exp_err, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL %s {err,ready,bank_valid}: got %b required %b", tag,
                  {bus.err, bus.ready, bus.bank_valid}, {exp_err, 2'b10});
      end
   endtask

   task automatic test_reset();
      do_reset();
      check_idle_outputs("reset");
   endtask

   task automatic test_single_packet();
      logic [31:0] d;
      do_reset();
      send_pkt(44, 1'b1, 1'b1, 1'b1, 1'b1);
      wait_bank("single");
      rd_word(0, d);
      n_tests++;
      if (d !== 32'h03020100) begin
         n_fail++; $display("FAIL single word0: got %h required 03020100", d);
      end
      rd_word(10, d);
      n_tests++;
      if (d !== 32'h2B2A2928) begin
         n_fail++; $display("FAIL single word10: got %h required 2B2A2928", d);
      end
      n_tests++;
      if (bus.ready !== 1'b1) begin
         n_fail++; $display("FAIL single ready: got %0b required 1", bus.ready);
      end
      read_bank("single", 1'b1);
   endtask

   task automatic test_back_to_back();
      send_pkt(4 * $urandom_range(11, 26), 1'b0, 1'b1, 1'b1, 1'b1);
      send_pkt(4 * $urandom_range(11, 26), 1'b0, 1'b1, 1'b1, 1'b0);
      read_bank("b2b_first", 1'b1);
      read_bank("b2b_second", 1'b1);
   endtask

   task automatic test_init();
      logic [4:0] payload[2];
      int pulses;
      logic [4:0] got;
      payload[0] = 5'h15;
      payload[1] = 5'($urandom);
      for (int k = 0; k < 2; k++) begin
         pulses = 0; got = '0;
         send_byte({payload[k], 3'b001}, 1'b1);
         repeat (6) begin
            if (bus.init_valid) begin pulses++; got = bus.init_dout; end
            @(posedge clk); #1;
         end
         n_tests++;
         if (pulses != 1 || got !== payload[k]) begin
            n_fail++;
            $display("FAIL init%0d: pulses=%0d dout=%h required 1/%h", k, pulses, got, payload[k]);
         end
         n_tests++;
         if ({bus.ready, bus.bank_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL init%0d_banks {ready,bank_valid}: got %b required 10", k,
                     {bus.ready, bus.bank_valid});
         end
      end
   endtask

   task automatic test_stall();
      int seen0;
      seen0 = afull_cnt;
      fork
         begin
            bus.rd_en = 1'b1; bus.rd_addr = '0;
            repeat (80) @(posedge clk);
            #1 bus.rd_en = 1'b0;
         end
         send_pkt(4 * PKT_WORDS, 1'b0, 1'b1, 1'b0, 1'b0);
      join
      n_tests++;
      if (afull_cnt == seen0) begin
         n_fail++; $display("FAIL stall_afull: afull never seen, required assertion");
      end
      n_tests++;
      if (bus.err !== 1'b0) begin
         n_fail++; $display("FAIL stall_err: got %0b required 0", bus.err);
      end
      read_bank("stall", 1'b0);
   endtask

   task automatic test_bad_end();
      do_reset();
      send_pkt(43, 1'b0, 1'b0, 1'b0, 1'b0);
      check_err("bad_end", 1'b1);
      send_pkt(4 * $urandom_range(11, 26), 1'b0, 1'b1, 1'b0, 1'b0);
      read_bank("after_bad_end", 1'b1);
   endtask

   task automatic test_errors();
      do_reset();
      bus.bank_done = 1'b1;
      @(posedge clk); #1;
      bus.bank_done = 1'b0;
      check_err("stray_done", 1'b1);
      do_reset();
      send_pkt(110, 1'b0, 1'b0, 1'b0, 1'b0);
      check_err("too_long", 1'b1);
      send_pkt(4 * $urandom_range(11, 26), 1'b0, 1'b1, 1'b0, 1'b0);
      read_bank("after_too_long", 1'b1);
   endtask

   task automatic test_reset_mid();
      do_reset();
      send_byte(8'h00, 1'b1);
      for (int i = 0; i < 20; i++) send_byte(8'($urandom), 1'b0);
      rst_n = 1'b0;
      #2;
      check_idle_outputs("reset_mid");
      @(posedge clk); #1;
      rst_n = 1'b1;
      send_pkt(4 * $urandom_range(11, 26), 1'b0, 1'b1, 1'b1, 1'b1);
      read_bank("after_reset_mid", 1'b1);
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 8; k++) begin
         send_pkt(4 * $urandom_range(11, 26), 1'b0, 1'b1, 1'b0, 1'b0);
         if (exp_lens.size() == 2) read_bank("random", 1'b1);
      end
      while (exp_lens.size() > 0) read_bank("random_drain", 1'b1);
      n_tests++;
      if (bus.err !== 1'b0) begin
         n_fail++; $display("FAIL random_err: got %0b required 0", bus.err);
      end
   endtask

   initial begin
      test_reset();
      test_single_packet();
      test_back_to_back();
      test_init();
      test_stall();
      test_bad_end();
      test_errors();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
